// File: rtl/emac_send_gtx.sv
// rtl/emac_send_gtx.sv - GMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, inter-frame gap.
module emac_send_gtx #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_FRAME = 60,
    parameter bit PAD_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_data_last,
    output logic       tx_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_abort
);

    // state_q names what is on the wire this cycle; ABORT is the single tx_er cycle.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SFD   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_PAD   = 3'd4;
    localparam logic [2:0] S_FCS   = 3'd5;
    localparam logic [2:0] S_IFG   = 3'd6;
    localparam logic [2:0] S_ABORT = 3'd7;

    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [1:0]  fcs_cnt_q, fcs_cnt_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;
    logic [31:0] crc_q, crc_d;

    logic [7:0]  gmii_txd_q, gmii_txd_d;
    logic        gmii_tx_en_q, gmii_tx_en_d;
    logic        gmii_tx_er_q, gmii_tx_er_d;
    logic        tx_ready_q, tx_ready_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_done_q, tx_done_d;
    logic        tx_abort_q, tx_abort_d;

    logic [10:0] byte_inc;
    logic [31:0] fcs_word;
    logic [1:0]  fcs_sel;
    logic [2:0]  gap_state;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign byte_inc  = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign fcs_word  = ~crc_q;
    assign fcs_sel   = fcs_cnt_q + 2'd1;
    // The IDLE cycle that samples the next frame counts as the last gap cycle.
    assign gap_state = (IFG_BYTES > 1) ? S_IFG : S_IDLE;

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        fcs_cnt_d    = fcs_cnt_q;
        ifg_cnt_d    = ifg_cnt_q;
        crc_d        = crc_q;
        gmii_txd_d   = 8'h00;
        gmii_tx_en_d = 1'b0;
        gmii_tx_er_d = 1'b0;
        tx_ready_d   = 1'b0;
        tx_done_d    = 1'b0;
        tx_abort_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_data_valid) begin
                    state_d      = S_PRE;
                    pre_cnt_d    = 3'd0;
                    gmii_txd_d   = 8'h55;
                    gmii_tx_en_d = 1'b1;
                end
            end
            S_PRE: begin
                gmii_tx_en_d = 1'b1;
                if (pre_cnt_q == 3'd6) begin
                    state_d    = S_SFD;
                    gmii_txd_d = 8'hD5;
                    tx_ready_d = 1'b1;
                    crc_d      = 32'hFFFFFFFF;
                    byte_cnt_d = 11'd0;
                end else begin
                    pre_cnt_d  = pre_cnt_q + 3'd1;
                    gmii_txd_d = 8'h55;
                end
            end
            S_SFD, S_DATA, S_PAD: begin
                gmii_tx_en_d = 1'b1;
                if (tx_ready_q) begin
                    if (tx_data_valid) begin
                        state_d    = S_DATA;
                        gmii_txd_d = tx_data;
                        crc_d      = crc_next(crc_q, tx_data);
                        byte_cnt_d = byte_inc;
                        tx_ready_d = !tx_data_last;
                    end else begin
                        state_d      = S_ABORT;
                        gmii_tx_er_d = 1'b1;
                        tx_abort_d   = 1'b1;
                    end
                end else if (PAD_EN && (byte_cnt_q < MIN_LEN)) begin
                    state_d    = S_PAD;
                    crc_d      = crc_next(crc_q, 8'h00);
                    byte_cnt_d = byte_inc;
                end else begin
                    state_d    = S_FCS;
                    fcs_cnt_d  = 2'd0;
                    gmii_txd_d = fcs_word[7:0];
                end
            end
            S_FCS: begin
                if (fcs_cnt_q == 2'd3) begin
                    state_d   = gap_state;
                    ifg_cnt_d = 8'd1;
                end else begin
                    gmii_tx_en_d = 1'b1;
                    fcs_cnt_d    = fcs_sel;
                    gmii_txd_d   = fcs_word[{fcs_sel, 3'b000} +: 8];
                    tx_done_d    = (fcs_cnt_q == 2'd2);
                end
            end
            S_ABORT: begin
                state_d   = gap_state;
                ifg_cnt_d = 8'd1;
                crc_d     = 32'hFFFFFFFF;
            end
            S_IFG: begin
                if (ifg_cnt_q >= IFG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        tx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pre_cnt_q    <= 3'd0;
            byte_cnt_q   <= 11'd0;
            fcs_cnt_q    <= 2'd0;
            ifg_cnt_q    <= 8'd0;
            crc_q        <= 32'hFFFFFFFF;
            gmii_txd_q   <= 8'h00;
            gmii_tx_en_q <= 1'b0;
            gmii_tx_er_q <= 1'b0;
            tx_ready_q   <= 1'b0;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_abort_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            fcs_cnt_q    <= fcs_cnt_d;
            ifg_cnt_q    <= ifg_cnt_d;
            crc_q        <= crc_d;
            gmii_txd_q   <= gmii_txd_d;
            gmii_tx_en_q <= gmii_tx_en_d;
            gmii_tx_er_q <= gmii_tx_er_d;
            tx_ready_q   <= tx_ready_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
            tx_abort_q   <= tx_abort_d;
        end
    end

    assign gmii_txd   = gmii_txd_q;
    assign gmii_tx_en = gmii_tx_en_q;
    assign gmii_tx_er = gmii_tx_er_q;
    assign tx_ready   = tx_ready_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;
    assign tx_abort   = tx_abort_q;

endmodule

// File: tb/tb_emac_send_gtx.sv
// tb/tb_emac_send_gtx.sv - directed bench for emac_send_gtx (padded and unpadded instances, shared stimulus).
module tb_emac_send_gtx;

    localparam int DEPTH = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_data_last = 1'b0;

    logic [7:0] txd [2];
    logic       en [2], er [2], rdy [2], busy [2], done [2], abrt [2];

    emac_send_gtx #(.IFG_BYTES(12), .MIN_FRAME(60), .PAD_EN(1'b1)) dut_pad (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_data_last(tx_data_last), .tx_ready(rdy[0]), .gmii_txd(txd[0]),
        .gmii_tx_en(en[0]), .gmii_tx_er(er[0]), .tx_busy(busy[0]),
        .tx_done(done[0]), .tx_abort(abrt[0])
    );

    emac_send_gtx #(.IFG_BYTES(12), .MIN_FRAME(60), .PAD_EN(1'b0)) dut_nopad (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_data_last(tx_data_last), .tx_ready(rdy[1]), .gmii_txd(txd[1]),
        .gmii_tx_en(en[1]), .gmii_tx_er(er[1]), .tx_busy(busy[1]),
        .tx_done(done[1]), .tx_abort(abrt[1])
    );

    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] c_txd  [2][DEPTH];
    logic       c_en   [2][DEPTH];
    logic       c_er   [2][DEPTH];
    logic       c_rdy  [2][DEPTH];
    logic       c_done [2][DEPTH];
    logic       c_abrt [2][DEPTH];
    int         cap_n = 0;
    logic       cap_on = 1'b0;

    always @(negedge clk) begin
        if (!cap_on) begin
            cap_n <= 0;
        end else if (cap_n < DEPTH) begin
            for (int d = 0; d < 2; d++) begin
                c_txd[d][cap_n]  <= txd[d];
                c_en[d][cap_n]   <= en[d];
                c_er[d][cap_n]   <= er[d];
                c_rdy[d][cap_n]  <= rdy[d];
                c_done[d][cap_n] <= done[d];
                c_abrt[d][cap_n] <= abrt[d];
            end
            cap_n <= cap_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'h31 + 8'(i);
            1:       return 8'(i * 7 + 3);
            default: return 8'(i) ^ 8'hA5;
        endcase
    endfunction

    // Bit-serial reference CRC over payload then zero pad, returned already inverted.
    function automatic logic [31:0] exp_fcs(input int kind, input int n, input int padto);
        logic [31:0] crc;
        logic [7:0]  b;
        int          tot;
        crc = 32'hFFFFFFFF;
        tot = (n > padto) ? n : padto;
        for (int i = 0; i < tot; i++) begin
            b = (i < n) ? pat(kind, i) : 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (crc[0] ^ b[j]) crc = {1'b0, crc[31:1]} ^ 32'hEDB88320;
                else               crc = {1'b0, crc[31:1]};
            end
        end
        return ~crc;
    endfunction

    task automatic cap_start;
        @(posedge clk); #1 cap_on = 1'b1;
    endtask

    task automatic cap_stop;
        @(posedge clk); #1 cap_on = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1; tx_data_valid = 1'b0; tx_data_last = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input int n, input int drop_at, input int kind, input bit hold);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 4000) begin
            @(negedge clk);
            tx_data       = pat(kind, i);
            tx_data_last  = (i == n - 1);
            tx_data_valid = (i != drop_at);
            if (rdy[0]) i = (i == drop_at) ? n : i + 1;
            cyc++;
        end
        check("drv_budget", 32'(cyc < 4000), 32'd1);
        if (!hold) begin
            @(negedge clk);
            tx_data_valid = 1'b0;
            tx_data_last  = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input int d, input int from, input int kind,
                               input int n, input int padto, output int s, output int e);
        int len, tot, perr, p, rat, rcnt;
        logic [7:0]  exb;
        logic [31:0] fcs;
        tot = (n > padto) ? n : padto;
        s = -1;
        for (int k = from; k < cap_n; k++) if (s < 0 && c_en[d][k]) s = k;
        check({tag, "_found"}, 32'(s >= 0), 32'd1);
        if (s < 0) begin
            e = from;
            return;
        end
        len = 0;
        while (s + len < cap_n && c_en[d][s + len]) len++;
        e = s + len;
        check({tag, "_len"}, 32'(len), 32'(12 + tot));
        perr = 0;
        for (int k = 0; k < 7; k++) if (c_txd[d][s + k] !== 8'h55) perr++;
        if (c_txd[d][s + 7] !== 8'hD5) perr++;
        for (int k = 0; k < tot; k++) begin
            exb = (k < n) ? pat(kind, k) : 8'h00;
            if (c_txd[d][s + 8 + k] !== exb) perr++;
        end
        check({tag, "_bytes_bad"}, 32'(perr), 32'd0);
        p = s + 8 + tot;
        fcs = {c_txd[d][p + 3], c_txd[d][p + 2], c_txd[d][p + 1], c_txd[d][p]};
        check({tag, "_fcs"}, fcs, exp_fcs(kind, n, padto));
        check({tag, "_done"}, {31'd0, c_done[d][p + 3]}, 32'd1);
        rat = -1;
        for (int k = from; k < cap_n; k++) if (rat < 0 && c_rdy[d][k]) rat = k;
        check({tag, "_rdy_ofs"}, 32'(rat - s), 32'd7);
        rcnt = 0;
        while (rat >= 0 && rat + rcnt < cap_n && c_rdy[d][rat + rcnt]) rcnt++;
        check({tag, "_rdy_cnt"}, 32'(rcnt), 32'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, e, s2, e2, cnt, len;
        logic [31:0] fw;

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("rst_txd",   {24'd0, txd[0]}, 32'd0);
        check("rst_en",    {31'd0, en[0]},  32'd0);
        check("rst_er",    {31'd0, er[0]},  32'd0);
        check("rst_rdy",   {31'd0, rdy[0]}, 32'd0);
        check("rst_busy",  {31'd0, busy[0]}, 32'd0);
        check("rst_done",  {31'd0, done[0]}, 32'd0);
        check("rst_abort", {31'd0, abrt[0]}, 32'd0);
        check("rst_en_np", {31'd0, en[1]},  32'd0);
        rst = 1'b0;

        // tx_data_last alone must not start a frame.
        tx_data_last = 1'b1;
        repeat (5) @(negedge clk);
        check("last_only_busy", {31'd0, busy[0]}, 32'd0);
        check("last_only_en",   {31'd0, en[0]},   32'd0);
        tx_data_last = 1'b0;

        // "123456789": unpadded FCS is the well-known CBF43926.
        do_reset();
        cap_start();
        send_frame(9, -1, 0, 1'b0);
        repeat (100) @(negedge clk);
        cap_stop();
        check_frame("nopad9", 1, 0, 0, 9, 0, s, e);
        fw = {c_txd[1][s + 20], c_txd[1][s + 19], c_txd[1][s + 18], c_txd[1][s + 17]};
        check("nopad9_fcs_const", fw, 32'hCBF43926);
        check_frame("pad9", 0, 0, 0, 9, 60, s, e);

        // 14-byte payload padded to 60.
        do_reset();
        cap_start();
        send_frame(14, -1, 1, 1'b0);
        repeat (100) @(negedge clk);
        cap_stop();
        check_frame("pad14", 0, 0, 1, 14, 60, s, e);

        // Back-to-back 64-byte frames with valid held across the gap.
        do_reset();
        cap_start();
        send_frame(64, -1, 1, 1'b1);
        send_frame(64, -1, 2, 1'b0);
        repeat (100) @(negedge clk);
        cap_stop();
        check_frame("b2b_f1", 0, 0, 1, 64, 60, s, e);
        check_frame("b2b_f2", 0, e, 2, 64, 60, s2, e2);
        check("b2b_gap", 32'(s2 - e), 32'd12);

        // Underrun at payload byte 20, then a clean frame right behind it.
        do_reset();
        cap_start();
        send_frame(40, 20, 1, 1'b0);
        send_frame(30, -1, 2, 1'b0);
        repeat (100) @(negedge clk);
        cap_stop();
        s = -1;
        for (int k = 0; k < cap_n; k++) if (s < 0 && c_en[0][k]) s = k;
        if (s < 0) s = 0;
        len = 0;
        while (s + len < cap_n && c_en[0][s + len]) len++;
        check("abort_len",   32'(len), 32'd29);
        check("abort_er",    {31'd0, c_er[0][s + 28]},   32'd1);
        check("abort_en",    {31'd0, c_en[0][s + 28]},   32'd1);
        check("abort_txd",   {24'd0, c_txd[0][s + 28]},  32'd0);
        check("abort_pulse", {31'd0, c_abrt[0][s + 28]}, 32'd1);
        cnt = 0;
        for (int k = s; k < s + 41; k++) if (c_done[0][k]) cnt++;
        check("abort_no_done", 32'(cnt), 32'd0);
        cnt = 0;
        for (int k = 0; k < cap_n; k++) if (c_abrt[0][k]) cnt++;
        check("abort_count", 32'(cnt), 32'd1);
        check_frame("post_abort", 0, s + 29, 2, 30, 60, s2, e2);
        check("abort_gap", 32'(s2 - (s + 29)), 32'd12);

        // Reset in the middle of padding, then a fresh frame.
        do_reset();
        send_frame(14, -1, 1, 1'b0);
        repeat (10) @(negedge clk);
        check("mid_pad_en", {31'd0, en[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_en",    {31'd0, en[0]},   32'd0);
        check("mid_rst_busy",  {31'd0, busy[0]}, 32'd0);
        check("mid_rst_txd",   {24'd0, txd[0]},  32'd0);
        check("mid_rst_done",  {31'd0, done[0]}, 32'd0);
        check("mid_rst_abort", {31'd0, abrt[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        cap_start();
        send_frame(14, -1, 2, 1'b0);
        repeat (100) @(negedge clk);
        cap_stop();
        check_frame("after_rst", 0, 0, 2, 14, 60, s, e);

        // Full-size 1514-byte payload.
        do_reset();
        cap_start();
        send_frame(1514, -1, 1, 1'b0);
        repeat (40) @(negedge clk);
        cap_stop();
        check_frame("max1514", 0, 0, 1, 1514, 60, s, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
